// File: rtl/jtframe_pocket_dwnld.sv
// rtl/jtframe_pocket_dwnld.sv - Pocket APF bridge writes to paced JTFRAME ioctl byte downloads
//
// Bridge data writes inside the data window are queued as 32-bit big-endian
// words and replayed as single-byte ioctl writes, one pulse every WR_GAP+1
// cycles. A control register starts/stops the download session and reports
// status.
//
// Ports:
//   clk, rst_n        system clock, asynchronous active-low reset
//   bridge_addr       bridge address (already synchronised to clk)
//   bridge_wr         one-cycle write strobe
//   bridge_wr_data    write data, big-endian
//   bridge_rd         one-cycle read strobe
//   bridge_rd_data    read data, valid the cycle after bridge_rd, held until next read
//   ioctl_addr        byte address of the current download byte
//   ioctl_dout        download byte
//   ioctl_wr          one-cycle byte write pulse
//   ioctl_ram         session targets RAM rather than ROM
//   downloading       download session active
module jtframe_pocket_dwnld #(
  parameter logic [31:0] DATA_BASE = 32'h1000_0000,
  parameter logic [31:0] CTRL_ADDR = 32'hF000_0000,
  parameter int unsigned WR_GAP    = 4,
  parameter int unsigned AW        = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] bridge_addr,
  input  logic        bridge_wr,
  input  logic [31:0] bridge_wr_data,
  input  logic        bridge_rd,
  output logic [31:0] bridge_rd_data,
  output logic [24:0] ioctl_addr,
  output logic [7:0]  ioctl_dout,
  output logic        ioctl_wr,
  output logic        ioctl_ram,
  output logic        downloading
);

  localparam int unsigned DEPTH    = 1 << AW;
  localparam logic [3:0]  GAP_LAST = 4'(WR_GAP - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BYTE = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t state, state_n;

  // Address decode. The unsigned offset check covers both window edges:
  // addresses below DATA_BASE wrap to a huge offset and fail the test.
  logic [31:0] off;
  logic [24:0] off_al;
  logic        in_win;
  logic        is_ctrl;

  assign off     = bridge_addr - DATA_BASE;
  assign off_al  = off[24:0] & ~25'd3;
  assign in_win  = (off[31:25] == 7'd0);
  assign is_ctrl = (bridge_addr == CTRL_ADDR);

  // Word FIFO: each entry is {word byte offset, data}
  logic [56:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          fifo_full;
  logic          fifo_empty;
  logic          data_wr;
  logic          push;
  logic          drop;
  logic          pop;
  logic [56:0]   head;

  // count never exceeds DEPTH, so its top bit alone means full
  assign fifo_full  = count[AW];
  assign fifo_empty = (count == '0);
  assign data_wr    = bridge_wr & in_win & downloading;
  // Full is judged on the registered count: a pop this cycle does not make room
  assign push       = data_wr & ~fifo_full;
  assign drop       = data_wr & fifo_full;
  assign head       = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {off_al, bridge_wr_data};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Serialiser: next-state and strobes
  logic [3:0]  gap_cnt;
  logic [1:0]  idx;
  logic [23:0] rest;
  logic [24:0] base;
  logic        advance;

  always_comb begin
    state_n = state;
    pop     = 1'b0;
    advance = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_n = BYTE;
        end
      end
      BYTE: begin
        state_n = GAP;
      end
      GAP: begin
        if (gap_cnt == GAP_LAST) begin
          if (idx != 2'd3) begin
            advance = 1'b1;
            state_n = BYTE;
          end else if (!fifo_empty) begin
            // Chain straight into the next word to keep the pulse pitch uniform
            pop     = 1'b1;
            state_n = BYTE;
          end else begin
            state_n = IDLE;
          end
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Address/data are loaded on entry to BYTE so they are valid during the
  // pulse and stay put through the following gap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gap_cnt    <= '0;
      idx        <= '0;
      rest       <= '0;
      base       <= '0;
      ioctl_addr <= '0;
      ioctl_dout <= '0;
    end else begin
      if (state == GAP) begin
        gap_cnt <= gap_cnt + 4'd1;
      end else begin
        gap_cnt <= '0;
      end
      if (pop) begin
        rest       <= head[23:0];
        base       <= head[56:32];
        idx        <= 2'd0;
        ioctl_dout <= head[31:24];
        ioctl_addr <= head[56:32];
      end else if (advance) begin
        rest       <= {rest[15:0], 8'd0};
        idx        <= idx + 2'd1;
        ioctl_dout <= rest[23:16];
        ioctl_addr <= base + {23'd0, idx + 2'd1};
      end
    end
  end

  assign ioctl_wr = (state == BYTE);

  // Session control
  logic stop_pending;
  logic overflow;
  logic start;
  logic stop_req;
  logic stop_done;

  assign start     = bridge_wr & is_ctrl & ~downloading & bridge_wr_data[0];
  assign stop_req  = bridge_wr & is_ctrl & downloading & ~bridge_wr_data[0];
  // A write landing on the closing cycle keeps the session open so it is not stranded
  assign stop_done = stop_pending & fifo_empty & (state == IDLE) & ~push;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      downloading  <= 1'b0;
      ioctl_ram    <= 1'b0;
      overflow     <= 1'b0;
      stop_pending <= 1'b0;
    end else begin
      if (start) begin
        downloading <= 1'b1;
        ioctl_ram   <= bridge_wr_data[1];
        overflow    <= 1'b0;
      end else begin
        if (stop_done) begin
          downloading  <= 1'b0;
          stop_pending <= 1'b0;
        end else if (stop_req) begin
          stop_pending <= 1'b1;
        end
        if (drop) begin
          overflow <= 1'b1;
        end
      end
    end
  end

  // Status read
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bridge_rd_data <= '0;
    end else if (bridge_rd) begin
      bridge_rd_data <= is_ctrl ? {28'd0, overflow, fifo_empty, ioctl_ram, downloading} : 32'd0;
    end
  end

endmodule
